jtflane_pcm_cache: RTL
======================

# jtflane_pcm_cache

Two-channel PCM sample cache sitting between the K007232 PCM address outputs inside `jtflane_main` and a single 16-bit `jtframe_rom` slot. It converts byte-wide, mostly sequential sample reads into 16-bit SDRAM word fetches. Each channel holds two words: a current word and a prefetched next word, so steady playback rarely stalls on SDRAM. This frees one ROM slot versus wiring each channel to its own 8-bit slot.

## Interface
Parameters:
- `AW`, 17: byte address width per channel. Word address is `AW-1` bits.

Ports:
- `clk` in 1: system clock (24 MHz domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `cha_addr` in AW: channel A byte address.
- `cha_cs` in 1: channel A read request.
- `cha_dout` out 8: channel A sample byte.
- `cha_ok` out 1: `cha_dout` is valid for the current `cha_addr`.
- `chb_addr`, `chb_cs`, `chb_dout`, `chb_ok`: same as the A ports, for channel B.
- `slot_addr` out AW-1: word address to the ROM slot.
- `slot_cs` out 1: ROM slot request.
- `slot_ok` in 1: `slot_data` is valid for `slot_addr`.
- `slot_data` in 16: ROM word.

## Operation
- **Per-channel state:** two lines, `cur` and `nxt`. Each line holds a tag (AW-1 bits), a 16-bit data word and a valid bit.
- **Byte select:** `addr[0]=0` selects `data[7:0]`; `addr[0]=1` selects `data[15:8]`.
- **Hit in `cur`:** `addr[AW-1:1]` equals the `cur` tag and `cur` is valid.
- **Hit in `nxt`:** serve from `nxt` and promote it in the same edge: `cur <= nxt`, then `nxt.valid <= 0`.
- **Demand miss:** `cs` is high and neither line hits. Raise a demand request for word W = `addr[AW-1:1]`. The fill writes `cur` with tag W, valid 1.
- **Prefetch:** pending whenever `cur` is valid and `nxt` does not hold `cur.tag+1` (modulo 2^(AW-1); all-ones wraps to 0). The fill writes `nxt`.
- **Arbiter priority (fixed):** demand A > demand B > prefetch A > prefetch B.
- **Arbiter states:**
  - IDLE: if any request is pending, latch `slot_addr` and the owner/kind, then go to REQ.
  - REQ: `slot_cs=1` with `slot_addr` held stable. On `slot_ok`, write the owner line and go to GAP.
  - GAP: `slot_cs=0` for one cycle, then IDLE.
- **Stale fill:** if the owner's demand address changed during REQ, the fill is still written as issued. The next IDLE re-evaluates; the request is never aborted.
- **Fill vs promote on the same edge:** a fill targeting `nxt` while the same channel promotes `nxt` is written to `cur` instead, only if its tag equals the promoted tag plus 0. Otherwise the fill is dropped and `nxt` stays invalid.
- **`cs` low:** `ok=0`. Lines are kept, and prefetch continues.
- **Reset:** all valid bits cleared, FSM to IDLE, `slot_cs=0`, `slot_addr=0`, both `ok=0`, both `dout=0`. Reset takes effect mid-fetch with no completion.

## Timing
- **Registered outputs:** `ok_q(N+1) = cs(N) & hit(N)` and `dout(N+1) = byte(addr(N))`. Also `addr_q(N+1) = addr(N)`.
- **`ok` gating:** `chX_ok = ok_q & chX_cs & (chX_addr == addr_q)`. A changed address therefore never sees a stale `ok`.
- **Hit latency:** 1 cycle from `cs` with a stable address to `ok`.
- **Miss latency:** wait for IDLE, +1 cycle to enter REQ, + slot latency, +1 cycle for the line write, +1 cycle for the registered `ok`.
- **Slot handshake:** `slot_addr` is stable for the entire REQ state. `slot_cs` drops for at least one cycle between requests, because the slot compares addresses.
- **Lookups:** both channels can hit in the same cycle; lookups are independent and never stall each other.

## Structure
- **Package `jtflane_pcm_pkg`:**
  - FSM enum {IDLE, REQ, GAP}.
  - Owner encoding (CH_A=0, CH_B=1).
  - Kind encoding (DEMAND, PREFETCH).
- **Sub-module `jtflane_pcm_line`:** instantiated once per channel. It contains:
  - the two lines and hit/promote logic;
  - the `ok`/`dout` registers;
  - the `req_demand`/`req_pref`/`req_addr` outputs and the `fill_we`/`fill_nxt`/`fill_data` inputs.
- **Top level:** holds only the arbiter FSM and the slot registers.

## Test plan
- **Cold read:** after reset, A reads 0x00010 with slot latency 4 and data 0xBEEF.
  - `slot_addr=0x0008`.
  - `cha_ok` rises with `cha_dout=0xEF`.
  - A then prefetches `slot_addr=0x0009`.
- **Sequential play:** A steps 0x00010 to 0x0001F one byte every 8 cycles, with slot latency 4.
  - `cha_ok` arrives 1 cycle after every address change after the first.
  - `slot_addr` sequence is 0x0008, 0x0009 … 0x0010.
- **Priority:** A prefetch pending, and a B demand miss on 0x1FFFF arrives in IDLE.
  - B is served first with `slot_addr=0xFFFF`.
  - B's prefetch wraps to `slot_addr=0x0000`.
- **Address jump mid-fetch:** A changes 0x00020 to 0x04000 during REQ.
  - The fill for 0x0010 completes and is written.
  - `cha_ok` stays low, then a new demand issues for 0x2000.
- **Simultaneous hits:** A and B both hit in `cur` in the same cycle; both `ok` signals rise on the next cycle and `slot_cs` stays 0.
- **Reset mid-REQ:** `rst_n` goes low during REQ.
  - `slot_cs`, `cha_ok` and `chb_ok` go 0 immediately.
  - After release, a re-read of the previously cached address misses.

Source files
------------

// File: rtl/jtflane_pcm_pkg.sv
// Shared types for the two-channel PCM cache: arbiter states, fill owner and fill kind.
package jtflane_pcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } owner_e;

  typedef enum logic {
    KIND_DEMAND   = 1'b0,
    KIND_PREFETCH = 1'b1
  } kind_e;

endpackage

// File: rtl/jtflane_pcm_cache_if.sv
// Bundle of the two PCM byte channels and the 16-bit ROM slot seen by the cache.
interface jtflane_pcm_cache_if #(
  parameter int AW = 17
);
  logic [AW-1:0] cha_addr;
  logic          cha_cs;
  logic [7:0]    cha_dout;
  logic          cha_ok;
  logic [AW-1:0] chb_addr;
  logic          chb_cs;
  logic [7:0]    chb_dout;
  logic          chb_ok;
  logic [AW-2:0] slot_addr;
  logic          slot_cs;
  logic          slot_ok;
  logic [15:0]   slot_data;

  // The cache is the master of the ROM slot and serves the two PCM channels.
  modport master (
    input  cha_addr, cha_cs, chb_addr, chb_cs, slot_ok, slot_data,
    output cha_dout, cha_ok, chb_dout, chb_ok, slot_addr, slot_cs
  );

  modport slave (
    output cha_addr, cha_cs, chb_addr, chb_cs, slot_ok, slot_data,
    input  cha_dout, cha_ok, chb_dout, chb_ok, slot_addr, slot_cs
  );
endinterface

// File: rtl/jtflane_pcm_line.sv
// One channel of the PCM cache: current + prefetched word, hit/promote logic,
// registered byte output and the demand/prefetch request toward the arbiter.
module jtflane_pcm_line #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  output logic [7:0]    dout,
  output logic          ok,
  output logic          req_demand,
  output logic          req_pref,
  output logic [AW-2:0] req_addr,
  input  logic          fill_we,
  input  logic          fill_nxt,
  input  logic [AW-2:0] fill_tag,
  input  logic [15:0]   fill_data
);
  localparam int TW = AW - 1;

  logic [TW-1:0] word, pref_tag;
  logic [TW-1:0] cur_tag_q, cur_tag_d, nxt_tag_q, nxt_tag_d;
  logic [15:0]   cur_data_q, cur_data_d, nxt_data_q, nxt_data_d, hit_data;
  logic          cur_vld_q, cur_vld_d, nxt_vld_q, nxt_vld_d;
  logic          hit_cur, hit_nxt, promote;
  logic          ok_q, ok_d;
  logic [7:0]    dout_q, dout_d;
  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    word       = addr[AW-1:1];
    pref_tag   = cur_tag_q + TW'(1);
    hit_cur    = cur_vld_q && (cur_tag_q == word);
    hit_nxt    = !hit_cur && nxt_vld_q && (nxt_tag_q == word);
    promote    = cs && hit_nxt;
    req_demand = cs && !(hit_cur || hit_nxt);
    req_pref   = cur_vld_q && !(nxt_vld_q && (nxt_tag_q == pref_tag));
    req_addr   = req_demand ? word : pref_tag;

    ok_d     = cs && (hit_cur || hit_nxt);
    addr_d   = addr;
    hit_data = hit_nxt ? nxt_data_q : cur_data_q;
    dout_d   = dout_q;
    if (ok_d) dout_d = addr[0] ? hit_data[15:8] : hit_data[7:0];

    cur_tag_d  = cur_tag_q;
    cur_data_d = cur_data_q;
    cur_vld_d  = cur_vld_q;
    nxt_tag_d  = nxt_tag_q;
    nxt_data_d = nxt_data_q;
    nxt_vld_d  = nxt_vld_q;

    if (promote) begin
      cur_tag_d  = nxt_tag_q;
      cur_data_d = nxt_data_q;
      cur_vld_d  = 1'b1;
      nxt_vld_d  = 1'b0;
    end

    // A promote owns both lines this edge: a colliding prefetch fill only
    // survives if it carries the very word being promoted.
    if (fill_we) begin
      if (!promote) begin
        if (fill_nxt) begin
          nxt_tag_d  = fill_tag;
          nxt_data_d = fill_data;
          nxt_vld_d  = 1'b1;
        end else begin
          cur_tag_d  = fill_tag;
          cur_data_d = fill_data;
          cur_vld_d  = 1'b1;
        end
      end else if (fill_nxt && (fill_tag == nxt_tag_q)) begin
        cur_tag_d  = fill_tag;
        cur_data_d = fill_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_vld_q <= 1'b0;
      nxt_vld_q <= 1'b0;
      ok_q      <= 1'b0;
      dout_q    <= 8'd0;
      addr_q    <= '0;
    end else begin
      cur_vld_q <= cur_vld_d;
      nxt_vld_q <= nxt_vld_d;
      ok_q      <= ok_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_tag_q  <= cur_tag_d;
    cur_data_q <= cur_data_d;
    nxt_tag_q  <= nxt_tag_d;
    nxt_data_q <= nxt_data_d;
  end

  // ok is qualified by the live address so a moved address never sees old data.
  assign ok   = ok_q && cs && (addr == addr_q);
  assign dout = dout_q;

endmodule

// File: rtl/jtflane_pcm_cache.sv
// Two-channel PCM byte cache sharing one 16-bit ROM slot; this level only
// arbitrates between the channel requests and drives the slot handshake.
module jtflane_pcm_cache
  import jtflane_pcm_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  jtflane_pcm_cache_if.master bus
);
  logic          a_dem, a_pref, b_dem, b_pref;
  logic [AW-2:0] a_raddr, b_raddr;
  logic          fill_we_a, fill_we_b, fill_nxt;

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  kind_e         kind_q, kind_d;
  logic [AW-2:0] slot_addr_q, slot_addr_d;

  jtflane_pcm_line #(.AW(AW)) u_cha (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (bus.cha_addr),
    .cs         (bus.cha_cs),
    .dout       (bus.cha_dout),
    .ok         (bus.cha_ok),
    .req_demand (a_dem),
    .req_pref   (a_pref),
    .req_addr   (a_raddr),
    .fill_we    (fill_we_a),
    .fill_nxt   (fill_nxt),
    .fill_tag   (slot_addr_q),
    .fill_data  (bus.slot_data)
  );

  jtflane_pcm_line #(.AW(AW)) u_chb (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (bus.chb_addr),
    .cs         (bus.chb_cs),
    .dout       (bus.chb_dout),
    .ok         (bus.chb_ok),
    .req_demand (b_dem),
    .req_pref   (b_pref),
    .req_addr   (b_raddr),
    .fill_we    (fill_we_b),
    .fill_nxt   (fill_nxt),
    .fill_tag   (slot_addr_q),
    .fill_data  (bus.slot_data)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    kind_d      = kind_q;
    slot_addr_d = slot_addr_q;
    fill_we_a   = 1'b0;
    fill_we_b   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (a_dem) begin
          owner_d = CH_A; kind_d = KIND_DEMAND;   slot_addr_d = a_raddr;
        end else if (b_dem) begin
          owner_d = CH_B; kind_d = KIND_DEMAND;   slot_addr_d = b_raddr;
        end else if (a_pref) begin
          owner_d = CH_A; kind_d = KIND_PREFETCH; slot_addr_d = a_raddr;
        end else if (b_pref) begin
          owner_d = CH_B; kind_d = KIND_PREFETCH; slot_addr_d = b_raddr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // The fill is written as issued even if the owner has moved on meanwhile.
      ST_REQ: begin
        if (bus.slot_ok) begin
          fill_we_a = (owner_q == CH_A);
          fill_we_b = (owner_q == CH_B);
          state_d   = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= CH_A;
      kind_q      <= KIND_DEMAND;
      slot_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      kind_q      <= kind_d;
      slot_addr_q <= slot_addr_d;
    end
  end

  assign fill_nxt      = (kind_q == KIND_PREFETCH);
  assign bus.slot_cs   = (state_q == ST_REQ);
  assign bus.slot_addr = slot_addr_q;

endmodule
